// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_INC    = 4;
  localparam int unsigned RETIRED_W = 32;

  // Instruction field bit positions
  localparam int unsigned COND_MSB  = 31;
  localparam int unsigned COND_LSB  = 28;
  localparam int unsigned OP_MSB    = 27;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned FUNCT_MSB = 25;
  localparam int unsigned FUNCT_LSB = 20;
  localparam int unsigned RN_MSB    = 19;
  localparam int unsigned RN_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 12;
  localparam int unsigned RM_MSB    = 3;
  localparam int unsigned RM_LSB    = 0;
  localparam int unsigned IMM_MSB   = 23;
  localparam int unsigned IMM_LSB   = 0;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory req/ack bus between the fetch stage and memory.
interface fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_ack;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_ack);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_ack);
endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select (sequential vs aligned branch) and PC+8.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] next_pc_c,
  output logic [ADDR_W-1:0] pc_plus8_c
);

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] target_aligned;

  // Word-align the target by clearing its two low bits; sums wrap modulo 2^ADDR_W
  always_comb begin
    pc_plus4       = pc + ADDR_W'(PC_INC);
    pc_plus8_c     = pc + ADDR_W'(2 * PC_INC);
    target_aligned = branch_target & ~ADDR_W'(3);
    next_pc_c      = pc_src ? target_aligned : pc_plus4;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack handshake, instruction register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     ADDR_W   = 32,
  parameter int unsigned     DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_if.master              imem,
  input  logic                 stall,
  input  logic                 PCSrc,
  input  logic [ADDR_W-1:0]    BranchTarget,
  output logic [DATA_W-1:0]    Instr,
  output logic [3:0]           Cond,
  output logic [1:0]           Op,
  output logic [5:0]           Funct,
  output logic [3:0]           Rn,
  output logic [3:0]           Rd,
  output logic [3:0]           Rm,
  output logic [23:0]          Imm24,
  output logic [ADDR_W-1:0]    PC,
  output logic [ADDR_W-1:0]    PCPlus8,
  output logic                 instr_valid,
  output logic [RETIRED_W-1:0] retired
);

  fetch_state_e         state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [DATA_W-1:0]    instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic [RETIRED_W-1:0] retired_q, retired_d;
  logic [ADDR_W-1:0]    next_pc_c;
  logic [ADDR_W-1:0]    pc_plus8_c;

  fetch_next_pc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .pc           (pc_q),
    .pc_src       (PCSrc),
    .branch_target(BranchTarget),
    .next_pc_c    (next_pc_c),
    .pc_plus8_c   (pc_plus8_c)
  );

  // State and datapath registers; reset abandons any outstanding request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and datapath update; everything holds unless a transition fires
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Stall wins over PCSrc; the branch is re-sampled when stall drops
        if (!stall) begin
          pc_d      = next_pc_c;
          valid_d   = 1'b0;
          retired_d = retired_q + RETIRED_W'(1);
          state_d   = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request decoded from the state register only, so it cannot glitch
  assign imem.imem_req  = (state_q == ST_REQ);
  assign imem.imem_addr = pc_q;

  assign Instr       = instr_q;
  assign Cond        = instr_q[COND_MSB:COND_LSB];
  assign Op          = instr_q[OP_MSB:OP_LSB];
  assign Funct       = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign Rn          = instr_q[RN_MSB:RN_LSB];
  assign Rd          = instr_q[RD_MSB:RD_LSB];
  assign Rm          = instr_q[RM_MSB:RM_LSB];
  assign Imm24       = instr_q[IMM_MSB:IMM_LSB];
  assign PC          = pc_q;
  assign PCPlus8     = pc_plus8_c;
  assign instr_valid = valid_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic [31:0] Instr;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rn;
  logic [3:0]  Rd;
  logic [3:0]  Rm;
  logic [23:0] Imm24;
  logic [31:0] PC;
  logic [31:0] PCPlus8;
  logic        instr_valid;
  logic [31:0] retired;

  fetch_if #(.ADDR_W(32), .DATA_W(32)) imem ();

  fetch_unit #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem),
    .stall       (stall),
    .PCSrc       (PCSrc),
    .BranchTarget(BranchTarget),
    .Instr       (Instr),
    .Cond        (Cond),
    .Op          (Op),
    .Funct       (Funct),
    .Rn          (Rn),
    .Rd          (Rd),
    .Rm          (Rm),
    .Imm24       (Imm24),
    .PC          (PC),
    .PCPlus8     (PCPlus8),
    .instr_valid (instr_valid),
    .retired     (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what the fetch stage should hold, in transaction terms
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_have;     // an instruction is held for the consumer
  logic        m_fetching; // a request is outstanding
  logic        m_fresh;    // first cycle after reset release
  logic [31:0] m_retired;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0;
    m_instr   = 32'h0;
    m_have    = 1'b0;
    m_fetching = 1'b0;
    m_fresh   = 1'b1;
    m_retired = 32'h0;
  endtask

  // Apply the rules for one clock edge given the inputs presented at it
  task automatic model_edge(input logic ack, input logic [31:0] rdata,
                            input logic stl, input logic pcs, input logic [31:0] bt);
    if (m_fresh) begin
      m_fresh    = 1'b0;
      m_fetching = 1'b1;
    end else if (m_fetching) begin
      if (ack) begin
        m_instr    = rdata;
        m_have     = 1'b1;
        m_fetching = 1'b0;
      end
    end else if (m_have && !stl) begin
      m_pc       = pcs ? {bt[31:2], 2'b00} : m_pc + 32'd4;
      m_have     = 1'b0;
      m_retired  = m_retired + 32'd1;
      m_fetching = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [31:0] exp_p8;
    exp_p8 = m_pc + 32'd8;
    check("imem_req", imem.imem_req, m_fetching);
    if (m_fetching) check("imem_addr", imem.imem_addr, m_pc);
    check("Instr", Instr, m_instr);
    check("Cond", Cond, (m_instr >> 28) % 16);
    check("Op", Op, (m_instr >> 26) % 4);
    check("Funct", Funct, (m_instr >> 20) % 64);
    check("Rn", Rn, (m_instr >> 16) % 16);
    check("Rd", Rd, (m_instr >> 12) % 16);
    check("Rm", Rm, m_instr % 16);
    check("Imm24", Imm24, m_instr % (1 << 24));
    check("PC", PC, m_pc);
    check("PCPlus8", PCPlus8, exp_p8);
    check("instr_valid", instr_valid, m_have);
    check("retired", retired, m_retired);
  endtask

  // One clock: check at the negedge, drive, take the edge, update the model
  task automatic cycle(input logic ack, input logic [31:0] rdata,
                       input logic stl, input logic pcs, input logic [31:0] bt);
    check_all();
    imem.imem_ack   = ack;
    imem.imem_rdata = rdata;
    stall           = stl;
    PCSrc           = pcs;
    BranchTarget    = bt;
    @(posedge clk);
    if (rst_n) model_edge(ack, rdata, stl, pcs, bt);
    @(negedge clk);
  endtask

  initial begin
    rst_n           = 1'b0;
    stall           = 1'b0;
    PCSrc           = 1'b0;
    BranchTarget    = 32'h0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_req", imem.imem_req, 1'b0);
    check("rst_pc", PC, 32'h0);
    check_all();
    rst_n = 1'b1;

    // Zero-wait first fetch
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("t1_req", imem.imem_req, 1'b1);
    check("t1_addr", imem.imem_addr, 32'h0);
    cycle(1'b1, 32'hE280_1001, 1'b0, 1'b0, 32'h0);
    check("t1_instr", Instr, 32'hE280_1001);
    check("t1_cond", Cond, 4'hE);
    check("t1_op", Op, 2'b00);
    check("t1_funct", Funct, 6'b101000);
    check("t1_rd", Rd, 4'h1);
    check("t1_valid", instr_valid, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("t1_next_addr", imem.imem_addr, 32'h4);

    // Ack delayed three cycles
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
      check("t2_wait_valid", instr_valid, 1'b0);
      check("t2_wait_addr", imem.imem_addr, 32'h4);
    end
    cycle(1'b1, 32'h0A00_0002, 1'b0, 1'b0, 32'h0);
    check("t2_valid", instr_valid, 1'b1);

    // Branch with misaligned target
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    check("t3_addr", imem.imem_addr, 32'h0000_0100);
    check("t3_retired", retired, 32'd2);

    // Stall beats PCSrc, then sequential advance
    cycle(1'b1, 32'h1A00_0003, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0F00);
    check("t4_hold_pc", PC, 32'h0000_0100);
    check("t4_hold_instr", Instr, 32'h1A00_0003);
    check("t4_hold_ret", retired, 32'd2);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0F00);
    check("t4_addr", imem.imem_addr, 32'h0000_0104);

    // Asynchronous reset mid-request, then a late ack that must be ignored
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("t6_req_now", imem.imem_req, 1'b0);
    check("t6_pc_now", PC, 32'h0);
    check("t6_valid_now", instr_valid, 1'b0);
    model_reset();
    imem.imem_ack   = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    check("t6_late_ack_valid", instr_valid, 1'b0);
    check("t6_late_ack_instr", Instr, 32'h0);
    check("t6_restart_addr", imem.imem_addr, 32'h0);
    cycle(1'b1, 32'hE1A0_0000, 1'b0, 1'b0, 32'h0);

    // Wrap at the top of the address space
    cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    check("t5_pc_top", imem.imem_addr, 32'hFFFF_FFFC);
    check("t5_pc8_wrap", PCPlus8, 32'h0000_0004);
    cycle(1'b1, 32'hE3A0_0001, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("t5_wrap_addr", imem.imem_addr, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] bt;
      bt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom() % 16)) : $urandom();
      cycle(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 9) < 3),
            1'($urandom_range(0, 3) == 0), bt);
    end
    check_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the single-cycle control unit.
- Holds the PC and runs a req/ack handshake to instruction memory.
- Latches the returned word into an instruction register and presents the split fields (Cond, Op, Funct, Rd, Rn, Rm, Imm24) to the control unit.
- Consumes PCSrc and the branch target from the control unit / ALU to choose the next PC.

Parameters:
- ADDR_W, 32, PC / memory address width
- DATA_W, 32, instruction width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_W  fetch address (= PC)
- imem_rdata  in  DATA_W  instruction word, valid when imem_ack=1
- imem_ack  in  1  memory accepts request and returns data this cycle
- stall  in  1  downstream not ready; hold current instruction
- PCSrc  in  1  from control unit: take branch target
- BranchTarget  in  ADDR_W  branch / ALU result address
- Instr  out  DATA_W  instruction register
- Cond  out  4  Instr[31:28]
- Op  out  2  Instr[27:26]
- Funct  out  6  Instr[25:20]
- Rn  out  4  Instr[19:16]
- Rd  out  4  Instr[15:12]
- Rm  out  4  Instr[3:0]
- Imm24  out  24  Instr[23:0]
- PC  out  ADDR_W  address of the instruction in Instr
- PCPlus8  out  ADDR_W  PC+8, for register-file R15 reads
- instr_valid  out  1  Instr holds a valid instruction
- retired  out  32  count of consumed instructions

Behaviour:
- States:
  - IDLE: one cycle after reset release.
  - REQ: imem_req=1, waiting for ack.
  - EXEC: instruction valid, waiting for the consumer.
- rst_n=0 (async, any cycle, including mid-REQ):
  - state=IDLE, PC=RESET_PC, Instr=0, instr_valid=0, retired=0, imem_req=0.
  - An outstanding request is abandoned; no response is expected after reset.
- IDLE -> REQ unconditionally on the next edge.
- REQ:
  - imem_req=1, imem_addr=PC.
  - On an edge with imem_ack=1: Instr<=imem_rdata, instr_valid<=1, state<=EXEC.
  - imem_ack=0 keeps state REQ with imem_addr stable; there is no timeout.
- EXEC:
  - imem_req=0; Cond/Op/Funct/Rd etc. are combinational slices of Instr.
  - stall=1: hold everything (PC, Instr, instr_valid=1).
  - stall=0: on the edge, PC<=PCSrc ? {BranchTarget[ADDR_W-1:2],2'b00} : PC+4; instr_valid<=0; retired<=retired+1; state<=REQ.
- PCSrc and BranchTarget are sampled only in EXEC with stall=0. They are ignored in IDLE and REQ.
- imem_ack is ignored outside REQ.
- Latency:
  - Zero-wait memory (ack in the first REQ cycle): 2 cycles per instruction (REQ, EXEC).
  - First instr_valid=1 occurs 2 edges after reset release.
- Arithmetic:
  - PC+4 and PC+8 are modulo 2^ADDR_W; 0xFFFF_FFFC+4 = 0x0000_0000.
  - BranchTarget low 2 bits are forced to 0.
  - retired wraps from 0xFFFF_FFFF to 0.
- Simultaneous stall=1 with PCSrc=1: stall wins and PCSrc is re-evaluated on the cycle stall drops.
- All state (PC, Instr, state, counters) is registered. imem_req is decoded from state only, so it is glitch-free.

Decomposition:
- Package fetch_pkg:
  - state encoding (IDLE=2'd0, REQ=2'd1, EXEC=2'd2)
  - PC_INC=4
  - instruction field bit positions for Cond/Op/Funct/Rn/Rd/Rm/Imm24
- Sub-module fetch_next_pc: combinational next-PC mux (PC+4 vs aligned BranchTarget), plus PCPlus8. It is reusable by a later pipelined fetch.

Test Plan:
- Reset release, memory acks immediately with 0xE280_1001 -> imem_addr=0x0 in cycle 1; Instr=0xE280_1001, Cond=4'hE, Op=2'b00, Funct=6'b101000, Rd=4'h1, instr_valid=1 at edge 2; next fetch addr 0x4.
- Ack delayed 3 cycles -> imem_req stays 1 with imem_addr stable for 4 cycles; instr_valid stays 0 until the ack edge.
- EXEC with PCSrc=1, BranchTarget=0x0000_0103 -> next imem_addr=0x0000_0100; retired increments by 1.
- stall=1 for 5 cycles in EXEC with PCSrc=1 -> PC, Instr, retired unchanged; on stall=0 with PCSrc=0 -> next addr=PC+4.
- PC=0xFFFF_FFFC, no branch -> next imem_addr=0x0; PCPlus8 at PC=0xFFFF_FFFC reads 0x0000_0004.
- rst_n asserted mid-REQ (no ack yet) -> imem_req=0 and PC=RESET_PC immediately (before the next edge); a late ack while in IDLE is ignored; fetch restarts at 0x0.
